seq_detect_param: RTL and testbench

Parametrised serial bit-sequence detector, successor to the fixed 1011 detector. The pattern, its length (1..MAX_LEN) and overlap mode are runtime-loadable. The detector has an input qualifier, a registered one-cycle match pulse and a saturating match counter. It sits on a serial bit stream beside the other sequence detectors and resets into a 1011, overlapping configuration, so it drops in for the fixed detector.

---
 rtl/seq_detect_pkg.sv | 42 ++++
 rtl/seq_detect_param_if.sv | 33 +++
 rtl/seq_match_cmp.sv | 29 ++
 rtl/seq_detect_param.sv | 137 +++++++++++++
 tb/tb_seq_detect_param.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_detect_pkg.sv
// -----------------------------------------------------------------------------
// seq_detect_pkg
// Shared constants and helpers for the parametrised serial sequence detectors.
//   RST_PATTERN / RST_LEN / RST_OVERLAP : configuration loaded on reset, chosen
//                                         so a fresh detector behaves like the
//                                         fixed overlapping 1011 detector.
//   clamp_len()                         : maps a requested length into 1..max_len
//   len_mask()                          : low-'len' bits set, ((1<<len)-1)
// -----------------------------------------------------------------------------
package seq_detect_pkg;

    localparam logic [63:0]  RST_PATTERN = 64'b1011;
    localparam int unsigned  RST_LEN     = 32'd4;
    localparam bit           RST_OVERLAP = 1'b1;

    // A zero length would match nothing meaningful, so it is treated as 1;
    // anything longer than the window is cut to the window size.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        int unsigned res;
        if (len == 32'd0) begin
            res = 32'd1;
        end else if (len > max_len) begin
            res = max_len;
        end else begin
            res = len;
        end
        return res;
    endfunction

    // Callers size-cast the result down to their own window width.
    function automatic logic [63:0] len_mask(input int unsigned len);
        logic [63:0] mask;
        if (len >= 32'd64) begin
            mask = '1;
        end else begin
            mask = (64'd1 << len) - 64'd1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// -----------------------------------------------------------------------------
// seq_detect_param_if
// Bit-stream, configuration and status signals of one sequence detector.
//   master : stream/config source (drives inp_bit, in_valid, cfg_load, pattern,
//            pat_len, overlap_en, count_clr; observes seq_seen, match_count, fill)
//   slave  : the detector itself (the opposite directions)
// -----------------------------------------------------------------------------
interface seq_detect_param_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1,
    parameter int CNT_W   = 8
);
    logic               inp_bit;
    logic               in_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   pat_len;
    logic               overlap_en;
    logic               count_clr;
    logic               seq_seen;
    logic [CNT_W-1:0]   match_count;
    logic [LEN_W-1:0]   fill;

    modport master (
        output inp_bit, in_valid, cfg_load, pattern, pat_len, overlap_en, count_clr,
        input  seq_seen, match_count, fill
    );

    modport slave (
        input  inp_bit, in_valid, cfg_load, pattern, pat_len, overlap_en, count_clr,
        output seq_seen, match_count, fill
    );
endinterface

// File: rtl/seq_match_cmp.sv
// -----------------------------------------------------------------------------
// seq_match_cmp
// Combinational masked compare: match is high when the low 'len' bits of
// window_next equal the low 'len' bits of pattern; higher bits are ignored.
//   window_next : candidate history, newest bit in bit 0
//   pattern     : target sequence, right-aligned
//   len         : active length (already clamped to 1..MAX_LEN)
//   match       : compare result
// -----------------------------------------------------------------------------
module seq_match_cmp #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic [MAX_LEN-1:0] window_next,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               match
);
    import seq_detect_pkg::*;

    logic [MAX_LEN-1:0] mask_s;

    // Masked equality of the active low bits.
    always_comb begin
        mask_s = MAX_LEN'(len_mask(32'(len)));
        match  = (((window_next ^ pattern) & mask_s) == {MAX_LEN{1'b0}});
    end

endmodule

// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
// Runtime-configurable serial bit-sequence detector with a one-cycle registered
// match pulse and a saturating match counter.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset (release must be synchronised upstream)
//   bus   : seq_detect_param_if.slave -- stream input, configuration load,
//           counter clear, and the registered seq_seen / match_count / fill
// -----------------------------------------------------------------------------
module seq_detect_param #(
    parameter int               MAX_LEN     = 8,
    parameter int               LEN_W       = $clog2(MAX_LEN) + 1,
    parameter int               CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(seq_detect_pkg::RST_PATTERN),
    parameter int unsigned      RST_LEN     = seq_detect_pkg::RST_LEN,
    parameter bit               RST_OVERLAP = seq_detect_pkg::RST_OVERLAP
) (
    input  logic                clk,
    input  logic                reset,
    seq_detect_param_if.slave   bus
);
    import seq_detect_pkg::*;

    localparam logic [LEN_W-1:0] RST_LEN_C = LEN_W'(clamp_len(RST_LEN, MAX_LEN));
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [MAX_LEN-1:0] cfg_pat_q,     cfg_pat_d;
    logic [LEN_W-1:0]   cfg_len_q,     cfg_len_d;
    logic               cfg_ovl_q,     cfg_ovl_d;
    logic [MAX_LEN-1:0] window_q,      window_d;
    logic [LEN_W-1:0]   fill_q,        fill_d;
    logic               seq_seen_q,    seq_seen_d;
    logic [CNT_W-1:0]   match_count_q, match_count_d;

    logic [MAX_LEN-1:0] window_shift_s;
    logic [LEN_W-1:0]   fill_inc_s;
    logic               pat_eq_s;
    logic               hit_s;

    // Candidate window/fill if the current bit is accepted.
    always_comb begin
        window_shift_s = {window_q[MAX_LEN-2:0], bus.inp_bit};
        if (fill_q >= cfg_len_q) begin
            fill_inc_s = cfg_len_q;
        end else begin
            fill_inc_s = fill_q + LEN_W'(1);
        end
    end

    seq_match_cmp #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_cmp (
        .window_next (window_shift_s),
        .pattern     (cfg_pat_q),
        .len         (cfg_len_q),
        .match       (pat_eq_s)
    );

    // A load discards the bit presented alongside it, so it can never hit.
    always_comb begin
        hit_s = bus.in_valid && !bus.cfg_load && (fill_inc_s == cfg_len_q) && pat_eq_s;
    end

    // Next-state for configuration, history and the match pulse.
    always_comb begin
        cfg_pat_d  = cfg_pat_q;
        cfg_len_d  = cfg_len_q;
        cfg_ovl_d  = cfg_ovl_q;
        window_d   = window_q;
        fill_d     = fill_q;
        seq_seen_d = 1'b0;
        if (bus.cfg_load) begin
            cfg_pat_d = bus.pattern;
            cfg_len_d = LEN_W'(clamp_len(32'(bus.pat_len), MAX_LEN));
            cfg_ovl_d = bus.overlap_en;
            window_d  = {MAX_LEN{1'b0}};
            fill_d    = {LEN_W{1'b0}};
        end else if (bus.in_valid) begin
            if (hit_s) begin
                seq_seen_d = 1'b1;
                // Without overlap the matched bits must not seed the next match.
                if (cfg_ovl_q) begin
                    window_d = window_shift_s;
                    fill_d   = fill_inc_s;
                end else begin
                    window_d = {MAX_LEN{1'b0}};
                    fill_d   = {LEN_W{1'b0}};
                end
            end else begin
                window_d = window_shift_s;
                fill_d   = fill_inc_s;
            end
        end else begin
            window_d = window_q;
            fill_d   = fill_q;
        end
    end

    // Saturating counter; a clear beats a same-cycle increment.
    always_comb begin
        match_count_d = match_count_q;
        if (bus.count_clr) begin
            match_count_d = {CNT_W{1'b0}};
        end else if (hit_s && (match_count_q != CNT_MAX)) begin
            match_count_d = match_count_q + CNT_W'(1);
        end else begin
            match_count_d = match_count_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_pat_q     <= RST_PATTERN;
            cfg_len_q     <= RST_LEN_C;
            cfg_ovl_q     <= RST_OVERLAP;
            window_q      <= {MAX_LEN{1'b0}};
            fill_q        <= {LEN_W{1'b0}};
            seq_seen_q    <= 1'b0;
            match_count_q <= {CNT_W{1'b0}};
        end else begin
            cfg_pat_q     <= cfg_pat_d;
            cfg_len_q     <= cfg_len_d;
            cfg_ovl_q     <= cfg_ovl_d;
            window_q      <= window_d;
            fill_q        <= fill_d;
            seq_seen_q    <= seq_seen_d;
            match_count_q <= match_count_d;
        end
    end

    assign bus.seq_seen    = seq_seen_q;
    assign bus.match_count = match_count_q;
    assign bus.fill        = fill_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_param
// Directed and random stimulus; a history-queue reference model predicts the
// outputs after every clock, and a monitor compares them against the detector.
// -----------------------------------------------------------------------------
module tb_seq_detect_param;
    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_TOP = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_detect_param_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    seq_detect_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic             seen;
        logic [CNT_W-1:0] cnt;
        logic [LEN_W-1:0] fill;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: bits received since the last clear, oldest first.
    bit   hist[$];
    bit [MAX_LEN-1:0] m_pat = 8'b0000_1011;
    int   m_len = 4;
    bit   m_ovl = 1'b1;
    int   m_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int model_fill();
        return (hist.size() < m_len) ? hist.size() : m_len;
    endfunction

    // Monitor: outputs are registered, so one prediction per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("seq_seen",    int'(bus.seq_seen),    int'(e.seen));
                check("match_count", int'(bus.match_count), int'(e.cnt));
                check("fill",        int'(bus.fill),        int'(e.fill));
            end
        end
    end

    // One clock of stimulus, issued at a falling edge; returns at the next one.
    task automatic do_cycle(input bit b, input bit v, input bit ld,
                            input bit [MAX_LEN-1:0] pat, input int len,
                            input bit ovl, input bit clr);
        bit   hit;
        exp_t e;
        bus.inp_bit    = b;
        bus.in_valid   = v;
        bus.cfg_load   = ld;
        bus.pattern    = pat;
        bus.pat_len    = LEN_W'(len);
        bus.overlap_en = ovl;
        bus.count_clr  = clr;
        hit = 1'b0;
        if (ld) begin
            m_pat = pat;
            m_len = len % (1 << LEN_W);
            if (m_len < 1) m_len = 1;
            if (m_len > MAX_LEN) m_len = MAX_LEN;
            m_ovl = ovl;
            hist.delete();
        end else if (v) begin
            hist.push_back(b);
            if (hist.size() > MAX_LEN) void'(hist.pop_front());
            if (hist.size() >= m_len) begin
                hit = 1'b1;
                for (int k = 0; k < m_len; k++)
                    if (hist[hist.size() - 1 - k] != m_pat[k]) hit = 1'b0;
            end
            if (hit && !m_ovl) hist.delete();
        end
        if (clr) m_cnt = 0;
        else if (hit && m_cnt < CNT_TOP) m_cnt = m_cnt + 1;
        e.seen = hit;
        e.cnt  = CNT_W'(m_cnt);
        e.fill = LEN_W'(model_fill());
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Stream cycle: configuration inputs carry junk that must be ignored.
    task automatic send(input bit b, input bit v, input bit clr);
        do_cycle(b, v, 1'b0, MAX_LEN'($urandom), int'($urandom_range(0, 15)),
                 1'($urandom), clr);
    endtask

    task automatic load(input bit [MAX_LEN-1:0] pat, input int len, input bit ovl,
                        input bit b, input bit v);
        do_cycle(b, v, 1'b1, pat, len, ovl, 1'b0);
    endtask

    // Sends the n low bits of 'bits', most significant first.
    task automatic feed(input logic [31:0] bits, input int n);
        logic [31:0] v;
        v = bits;
        for (int i = n - 1; i >= 0; i--) send(v[i], 1'b1, 1'b0);
    endtask

    task automatic clear_count();
        send(1'($urandom), 1'b0, 1'b1);
    endtask

    // Asynchronous assert mid-cycle, outputs checked before any clock edge.
    task automatic reset_pulse(input string name);
        bus.in_valid = 1'b0;
        bus.cfg_load = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        hist.delete();
        m_pat = 8'b0000_1011;
        m_len = 4;
        m_ovl = 1'b1;
        m_cnt = 0;
        check({name, "_seen"},  int'(bus.seq_seen),    0);
        check({name, "_count"}, int'(bus.match_count), 0);
        check({name, "_fill"},  int'(bus.fill),        model_fill());
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset          = 1'b0;
        bus.inp_bit    = 1'b0;
        bus.in_valid   = 1'b0;
        bus.cfg_load   = 1'b0;
        bus.pattern    = '0;
        bus.pat_len    = '0;
        bus.overlap_en = 1'b0;
        bus.count_clr  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_seen",  int'(bus.seq_seen),    0);
        check("rst_count", int'(bus.match_count), 0);
        check("rst_fill",  int'(bus.fill),        0);
        reset = 1'b1;

        // Reset configuration: 1011 overlapping, hits after bits 4 and 7.
        feed(32'b1011011, 7);

        // 110 non-overlapping, then 101 non-overlapping on the same stream.
        clear_count();
        load(8'b110, 3, 1'b0, 1'b0, 1'b0);
        feed(32'b110110110, 9);
        clear_count();
        load(8'b101, 3, 1'b0, 1'b0, 1'b0);
        feed(32'b110110110, 9);

        // 11 with and without overlap.
        clear_count();
        load(8'b11, 2, 1'b1, 1'b0, 1'b0);
        feed(32'b1111, 4);
        clear_count();
        load(8'b11, 2, 1'b0, 1'b0, 1'b0);
        feed(32'b1111, 4);

        // Valid gaps: invalid cycles carry random bits that must be skipped.
        clear_count();
        load(8'b1011, 4, 1'b1, 1'b0, 1'b0);
        begin
            logic [3:0] s;
            s = 4'b1011;
            for (int i = 3; i >= 0; i--) begin
                send(s[i], 1'b1, 1'b0);
                send(1'($urandom), 1'b0, 1'b0);
            end
        end

        // Load mid-pattern with a valid bit: that bit is dropped.
        feed(32'b101, 3);
        load(8'b1011, 4, 1'b1, 1'b1, 1'b1);
        feed(32'b1011, 4);

        // Counter saturation and clear-vs-hit priority.
        clear_count();
        load(8'b1, 1, 1'b1, 1'b0, 1'b0);
        feed(32'b11111, 5);
        send(1'b1, 1'b1, 1'b1);

        // Length clamps: 0 -> 1, MAX_LEN+3 -> MAX_LEN.
        load(8'b1, 0, 1'b0, 1'b0, 1'b0);
        feed(32'b101, 3);
        load(8'b1011_0011, MAX_LEN + 3, 1'b1, 1'b0, 1'b0);
        feed(32'b1_1011_0011, 9);

        // Reset during 1,0,1 of the default pattern, then a 1: no pulse.
        reset_pulse("rst_mid_a");
        feed(32'b101, 3);
        reset_pulse("rst_mid_b");
        feed(32'b1, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            if (r < 40)
                load(MAX_LEN'($urandom), int'($urandom_range(0, 11)), 1'($urandom),
                     1'($urandom), 1'($urandom));
            else if (r < 43)
                reset_pulse("rst_rand");
            else
                send(1'($urandom), ($urandom_range(0, 9) < 8), ($urandom_range(0, 99) < 3));
        end

        @(posedge clk);
        #2;
        check("queue_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
